// File: rtl/split_predict.sv
// split_predict: predict step of the DWT lifting datapath.
// Splits each frame of FRAME_LEN samples into even/odd phases and emits
// d[k] = x[2k+1] - ((x[2k] + x[2k+2]) >> 1) paired with x[2k]. At the frame
// end the missing x[2k+2] is mirrored from x[2k].
module split_predict #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] detail_cofficient,
    output logic [WIDTH-1:0] even_output,
    output logic             even_valid,
    output logic             detail_valid,
    input  logic             out_ready,
    output logic             frame_done
);

    localparam int PAIRS = FRAME_LEN / 2;
    localparam int KW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);

    typedef enum logic [1:0] {
        S_EVEN0 = 2'd0,
        S_ODD   = 2'd1,
        S_EVEN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_even_q, prev_even_d;
    logic [WIDTH-1:0] cur_odd_q, cur_odd_d;
    logic [KW-1:0]    k_q, k_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] detail_q, detail_d;
    logic [WIDTH-1:0] even_q, even_d;

    logic             xfer_s;
    logic             emit_s;
    logic             emit_final_s;
    logic [WIDTH-1:0] beat_odd_s;
    logic [WIDTH-1:0] beat_next_s;

    // Predict: odd minus the floor-average of its two even neighbours.
    // The sum keeps its carry bit so the average never overflows; the
    // subtraction wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] predict(
        input logic [WIDTH-1:0] odd,
        input logic [WIDTH-1:0] even_a,
        input logic [WIDTH-1:0] even_b
    );
        logic [WIDTH:0] sum;
        sum     = {1'b0, even_a} + {1'b0, even_b};
        predict = odd - sum[WIDTH:1];
    endfunction

    // Input stalls only while a produced beat is still waiting downstream.
    assign in_ready = !(valid_q && !out_ready);
    assign xfer_s   = in_valid && in_ready;

    assign detail_cofficient = detail_q;
    assign even_output       = even_q;
    assign detail_valid      = valid_q;
    assign even_valid        = valid_q;
    assign frame_done        = done_q;

    // Phase FSM: track even/odd position and decide when a beat is emitted.
    always_comb begin
        state_d      = state_q;
        prev_even_d  = prev_even_q;
        cur_odd_d    = cur_odd_q;
        k_d          = k_q;
        emit_s       = 1'b0;
        emit_final_s = 1'b0;
        beat_odd_s   = cur_odd_q;
        beat_next_s  = in_data;
        case (state_q)
            S_EVEN0: begin
                if (xfer_s) begin
                    prev_even_d = in_data;
                    state_d     = S_ODD;
                end else begin
                    state_d = S_EVEN0;
                end
            end
            S_ODD: begin
                if (xfer_s) begin
                    cur_odd_d = in_data;
                    if (k_q == K_LAST) begin
                        // Last pair: no x[2k+2] exists, mirror x[2k].
                        emit_s       = 1'b1;
                        emit_final_s = 1'b1;
                        beat_odd_s   = in_data;
                        beat_next_s  = prev_even_q;
                        k_d          = {KW{1'b0}};
                        state_d      = S_EVEN0;
                    end else begin
                        state_d = S_EVEN;
                    end
                end else begin
                    state_d = S_ODD;
                end
            end
            S_EVEN: begin
                if (xfer_s) begin
                    emit_s      = 1'b1;
                    beat_odd_s  = cur_odd_q;
                    beat_next_s = in_data;
                    prev_even_d = in_data;
                    k_d         = k_q + KW'(1);
                    state_d     = S_ODD;
                end else begin
                    state_d = S_EVEN;
                end
            end
            default: begin
                state_d = S_EVEN0;
                k_d     = {KW{1'b0}};
            end
        endcase
    end

    // Output register: load on emit, drop valid/done once consumed, data holds.
    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        detail_d = detail_q;
        even_d   = even_q;
        if (emit_s) begin
            valid_d  = 1'b1;
            done_d   = emit_final_s;
            detail_d = predict(beat_odd_s, prev_even_q, beat_next_s);
            even_d   = prev_even_q;
        end else if (out_ready) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else begin
            valid_d = valid_q;
            done_d  = done_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EVEN0;
            prev_even_q <= {WIDTH{1'b0}};
            cur_odd_q   <= {WIDTH{1'b0}};
            k_q         <= {KW{1'b0}};
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            detail_q    <= {WIDTH{1'b0}};
            even_q      <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            prev_even_q <= prev_even_d;
            cur_odd_q   <= cur_odd_d;
            k_q         <= k_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            detail_q    <= detail_d;
            even_q      <= even_d;
        end
    end

endmodule

// File: tb/tb_split_predict.sv
// Testbench for split_predict: directed frames plus random traffic,
// checked every cycle against a frame-buffer reference model.
module tb_split_predict;

    localparam int W  = 8;
    localparam int FL = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] detail_cofficient;
    logic [W-1:0] even_output;
    logic         even_valid;
    logic         detail_valid;
    logic         out_ready = 1'b1;
    logic         frame_done;

    split_predict #(.WIDTH(W), .FRAME_LEN(FL)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .detail_cofficient (detail_cofficient),
        .even_output       (even_output),
        .even_valid        (even_valid),
        .detail_valid      (detail_valid),
        .out_ready         (out_ready),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: samples of the current frame and the pending beat.
    int          frame_x[$];
    bit          m_pend = 1'b0;
    bit          m_fd   = 1'b0;
    logic [7:0]  m_d    = 8'd0;
    logic [7:0]  m_e    = 8'd0;
    bit          last_acc;
    logic [16:0] captured[$];
    logic [16:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pred(input int x_odd, input int x_a, input int x_b);
        int v;
        v = x_odd - ((x_a + x_b) / 2);
        return 8'(v & 255);
    endfunction

    function automatic logic [16:0] bt(input bit fd, input int d, input int e);
        return {fd, 8'(d), 8'(e)};
    endfunction

    // One clock cycle: drive at negedge, check in_ready, advance model, check outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic r);
        bit         exp_rdy;
        bit         beat;
        bit         fin;
        int         i;
        logic [7:0] bd;
        logic [7:0] be;
        rst      = r;
        in_valid = v;
        in_data  = d;
        out_ready = ordy;
        #1;
        exp_rdy = !(m_pend && !ordy);
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (!r && m_pend && ordy)
            captured.push_back({frame_done, detail_cofficient, even_output});
        last_acc = !r && v && exp_rdy;
        beat = 1'b0;
        fin  = 1'b0;
        bd   = 8'd0;
        be   = 8'd0;
        if (r) begin
            frame_x.delete();
            m_pend = 1'b0;
            m_fd   = 1'b0;
            m_d    = 8'd0;
            m_e    = 8'd0;
        end else begin
            if (last_acc) begin
                frame_x.push_back(int'(d));
                i = frame_x.size() - 1;
                if (i >= 2 && (i % 2) == 0) begin
                    beat = 1'b1;
                    bd   = pred(frame_x[i-1], frame_x[i-2], frame_x[i]);
                    be   = 8'(frame_x[i-2]);
                end
                if (i == FL - 1) begin
                    beat = 1'b1;
                    fin  = 1'b1;
                    bd   = pred(frame_x[i], frame_x[i-1], frame_x[i-1]);
                    be   = 8'(frame_x[i-1]);
                    frame_x.delete();
                end
            end
            if (beat) begin
                m_pend = 1'b1;
                m_fd   = fin;
                m_d    = bd;
                m_e    = be;
            end else if (ordy) begin
                m_pend = 1'b0;
                m_fd   = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_eq("detail_valid", 32'(detail_valid), 32'(m_pend));
        check_eq("even_valid", 32'(even_valid), 32'(m_pend));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
        check_eq("detail", 32'(detail_cofficient), 32'(m_d));
        check_eq("even", 32'(even_output), 32'(m_e));
    endtask

    // Offer one sample until accepted, with a bounded retry budget.
    task automatic send(input logic [7:0] d, input logic ordy);
        int n;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 50) begin
            step(1'b1, d, ordy, 1'b0);
            n++;
        end
        if (!last_acc) check_eq("send_timeout", 32'(last_acc), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b1, 1'b0);
    endtask

    // Compare consumed beats against the expected table, then clear both.
    task automatic check_beats(input string tag);
        check_eq({tag, "_count"}, 32'(captured.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j < captured.size()) check_eq(tag, 32'(captured[j]), 32'(exp_q[j]));
        end
        captured.delete();
        exp_q.delete();
    endtask

    initial begin
        int c0;
        @(negedge clk);
        step(1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 8'd0, 1'b1, 1'b1);
        captured.delete();

        // Basic frame
        send(8'd10, 1'b1); send(8'd20, 1'b1); send(8'd30, 1'b1); send(8'd40, 1'b1);
        idle(2);
        exp_q.push_back(bt(1'b0, 0, 10));
        exp_q.push_back(bt(1'b1, 10, 30));
        check_beats("basic");

        // Wrap arithmetic
        send(8'd100, 1'b1); send(8'd0, 1'b1); send(8'd50, 1'b1); send(8'd7, 1'b1);
        idle(2);
        exp_q.push_back(bt(1'b0, 181, 100));
        exp_q.push_back(bt(1'b1, 213, 50));
        check_beats("wrap");

        // Backpressure: hold the first beat for 3 cycles while x[3] is offered
        send(8'd10, 1'b1); send(8'd20, 1'b1); send(8'd30, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'd40, 1'b0, 1'b0);
            check_eq("bp_no_accept", 32'(last_acc), 32'd0);
        end
        send(8'd40, 1'b1);
        idle(2);
        exp_q.push_back(bt(1'b0, 0, 10));
        exp_q.push_back(bt(1'b1, 10, 30));
        check_beats("backpressure");

        // Back-to-back frames, one sample per cycle
        c0 = cyc;
        send(8'd10, 1'b1); send(8'd20, 1'b1); send(8'd30, 1'b1); send(8'd40, 1'b1);
        send(8'd1, 1'b1);  send(8'd2, 1'b1);  send(8'd3, 1'b1);  send(8'd4, 1'b1);
        check_eq("b2b_cycles", 32'(cyc - c0), 32'd8);
        idle(2);
        exp_q.push_back(bt(1'b0, 0, 10));
        exp_q.push_back(bt(1'b1, 10, 30));
        exp_q.push_back(bt(1'b0, 0, 1));
        exp_q.push_back(bt(1'b1, 1, 3));
        check_beats("b2b");

        // Reset mid-frame
        send(8'd10, 1'b1); send(8'd20, 1'b1); send(8'd30, 1'b1);
        step(1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 8'd0, 1'b1, 1'b1);
        captured.delete();
        send(8'd10, 1'b1); send(8'd20, 1'b1); send(8'd30, 1'b1); send(8'd40, 1'b1);
        idle(2);
        exp_q.push_back(bt(1'b0, 0, 10));
        exp_q.push_back(bt(1'b1, 10, 30));
        check_beats("reset_mid");

        // Input gaps
        send(8'd10, 1'b1); idle(2); send(8'd20, 1'b1); idle(2);
        send(8'd30, 1'b1); idle(2); send(8'd40, 1'b1); idle(2);
        exp_q.push_back(bt(1'b0, 0, 10));
        exp_q.push_back(bt(1'b1, 10, 30));
        check_beats("gaps");

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0)
                step(1'b0, 8'd0, 1'b1, 1'b1);
            else
                step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
        end
        captured.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
